// File: rtl/subr_pkg.sv
// Shared constants, state and strobe types for the subroutine sequencer (subr_ctrl).
package subr_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SP_W   = 3;

  localparam logic [NIB_W-1:0] OPC_JMS = 4'b0101;
  localparam logic [NIB_W-1:0] OPC_BBL = 4'b1100;

  localparam logic [SP_W-1:0] STK_SP_FULL  = 3'd7;
  localparam logic [SP_W-1:0] STK_SP_EMPTY = 3'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    JMS_OP2  = 3'd1,
    JMS_PUSH = 3'd2,
    BBL_POP  = 3'd3,
    BBL_WAIT = 3'd4,
    FAULT    = 3'd5
  } subr_state_t;

  // Single-cycle strobes driven towards the stack, PC and accumulator.
  typedef struct packed {
    logic push;
    logic pop;
    logic pc_load;
    logic acc_load;
    logic done;
  } subr_strb_t;

  // Return address of a two-byte call: the byte after the operand, wrapping at 4K.
  function automatic logic [ADDR_W-1:0] ret_addr(input logic [ADDR_W-1:0] pc);
    return ADDR_W'(pc + ADDR_W'(2));
  endfunction

endpackage

// File: rtl/subr_decode.sv
// Opcode classifier: flags JMS/BBL in the high nibble and passes the low nibble through.
module subr_decode
  import subr_pkg::*;
(
  input  logic [BYTE_W-1:0] inst_byte_i,
  output logic              is_jms_o,
  output logic              is_bbl_o,
  output logic [NIB_W-1:0]  nibble_o
);

  logic [NIB_W-1:0] opcode;

  assign opcode   = inst_byte_i[BYTE_W-1:NIB_W];
  assign is_jms_o = (opcode == OPC_JMS);
  assign is_bbl_o = (opcode == OPC_BBL);
  assign nibble_o = inst_byte_i[NIB_W-1:0];

endmodule

// File: rtl/subr_ctrl.sv
// JMS/BBL subroutine sequencer driving the return-address stack, PC redirect and accumulator load.
// Optional stack guard (overflow/underflow -> sticky FAULT) enabled by defining SUBR_STACK_GUARD_EN.
module subr_ctrl
  import subr_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              instValid,
  input  logic [BYTE_W-1:0] instByte,
  input  logic [ADDR_W-1:0] instPc,
  output logic              instReady,
  output logic              stkPush,
  output logic              stkPop,
  output logic [ADDR_W-1:0] stkPcIn,
  input  logic [ADDR_W-1:0] stkPcOut,
  input  logic [SP_W-1:0]   stkSp,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcNext,
  output logic              accLoad,
  output logic [NIB_W-1:0]  accData,
  output logic              done,
  output logic              fault
);

  subr_state_t       state_q, state_d;
  subr_strb_t        strb_q, strb_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic [NIB_W-1:0]  dat_q, dat_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic              pc_sel_q, pc_sel_d;

  logic              is_jms;
  logic              is_bbl;
  logic [NIB_W-1:0]  nibble;
  logic              accept;
  logic              guard_full;
  logic              guard_empty;

  subr_decode u_decode (
    .inst_byte_i (instByte),
    .is_jms_o    (is_jms),
    .is_bbl_o    (is_bbl),
    .nibble_o    (nibble)
  );

`ifdef SUBR_STACK_GUARD_EN
  assign guard_full  = (stkSp == STK_SP_FULL);
  assign guard_empty = (stkSp == STK_SP_EMPTY);
`else
  logic unused_sp;
  assign unused_sp   = ^stkSp;
  assign guard_full  = 1'b0;
  assign guard_empty = 1'b0;
`endif

  assign accept = instValid && ready_q;

  // Next-state, latch and strobe decode.
  always_comb begin
    state_d  = state_q;
    strb_d   = '0;
    target_d = target_q;
    ret_d    = ret_q;
    dat_d    = dat_q;
    fault_d  = fault_q;
    pc_sel_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_jms) begin
            if (guard_full) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end else begin
              state_d  = JMS_OP2;
              target_d = {nibble, BYTE_W'(0)};
              ret_d    = ret_addr(instPc);
            end
          end else if (is_bbl) begin
            if (guard_empty) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end else begin
              state_d    = BBL_POP;
              dat_d      = nibble;
              strb_d.pop = 1'b1;
            end
          end
        end
      end

      JMS_OP2: begin
        if (accept) begin
          state_d        = JMS_PUSH;
          target_d       = {target_q[ADDR_W-1:BYTE_W], instByte};
          strb_d.push    = 1'b1;
          strb_d.pc_load = 1'b1;
          strb_d.done    = 1'b1;
        end
      end

      JMS_PUSH: state_d = IDLE;

      // Popped address arrives one cycle after the pop strobe, so redirect from the stack port.
      BBL_POP: begin
        state_d         = BBL_WAIT;
        strb_d.pc_load  = 1'b1;
        strb_d.acc_load = 1'b1;
        strb_d.done     = 1'b1;
        pc_sel_d        = 1'b1;
      end

      BBL_WAIT: state_d = IDLE;

      FAULT: state_d = FAULT;

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == JMS_OP2);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= IDLE;
      strb_q   <= '0;
      target_q <= '0;
      ret_q    <= '0;
      dat_q    <= '0;
      ready_q  <= 1'b1;
      fault_q  <= 1'b0;
      pc_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      target_q <= target_d;
      ret_q    <= ret_d;
      dat_q    <= dat_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
      pc_sel_q <= pc_sel_d;
    end
  end

  assign instReady = ready_q;
  assign stkPush   = strb_q.push;
  assign stkPop    = strb_q.pop;
  assign stkPcIn   = ret_q;
  assign pcLoad    = strb_q.pc_load;
  assign pcNext    = pc_sel_q ? stkPcOut : target_q;
  assign accLoad   = strb_q.acc_load;
  assign accData   = dat_q;
  assign done      = strb_q.done;
  assign fault     = fault_q;

`ifndef SYNTHESIS
  a_push_pop_excl: assert property (@(posedge clk) disable iff (!rstN) !(stkPush && stkPop));
  a_push_pulse:    assert property (@(posedge clk) disable iff (!rstN) stkPush |=> !stkPush);
  a_pop_pulse:     assert property (@(posedge clk) disable iff (!rstN) stkPop |=> !stkPop);
  a_done_pulse:    assert property (@(posedge clk) disable iff (!rstN) done |=> !done);
`endif

endmodule

// File: tb/tb_subr_ctrl.sv
// Bench for subr_ctrl: directed call/return cases plus random fetch traffic against a transaction model.
module tb_subr_ctrl;
  import subr_pkg::*;

`ifdef SUBR_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic        push;
    logic        pop;
    logic        pcld;
    logic        accld;
    logic        done;
    logic        ready;
    logic        fault;
    logic [11:0] pcin;
    logic [11:0] pcnext;
    logic [3:0]  accd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        instValid;
  logic [7:0]  instByte;
  logic [11:0] instPc;
  logic        instReady;
  logic        stkPush;
  logic        stkPop;
  logic [11:0] stkPcIn;
  logic [11:0] stkPcOut = 12'h000;
  logic [2:0]  stkSp = 3'd0;
  logic        pcLoad;
  logic [11:0] pcNext;
  logic        accLoad;
  logic [3:0]  accData;
  logic        done;
  logic        fault;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  exp_t        e;
  exp_t        sched[$];
  logic [11:0] m_stk[$];
  bit          m_op2;
  bit          m_fault;
  logic [3:0]  m_hi;
  logic [11:0] m_ret;
  logic [11:0] emu[$];

  always #5 clk = ~clk;

  subr_ctrl dut (
    .clk       (clk),
    .rstN      (rstN),
    .instValid (instValid),
    .instByte  (instByte),
    .instPc    (instPc),
    .instReady (instReady),
    .stkPush   (stkPush),
    .stkPop    (stkPop),
    .stkPcIn   (stkPcIn),
    .stkPcOut  (stkPcOut),
    .stkSp     (stkSp),
    .pcLoad    (pcLoad),
    .pcNext    (pcNext),
    .accLoad   (accLoad),
    .accData   (accData),
    .done      (done),
    .fault     (fault)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Return-address stack: an unbounded LIFO whose pointer saturates at 7.
  initial forever begin
    @(negedge clk);
    if (stkPush) emu.push_back(stkPcIn);
    if (stkPop) stkPcOut = (emu.size() != 0) ? emu.pop_back() : 12'h000;
    stkSp = (emu.size() >= 7) ? 3'd7 : 3'(emu.size());
  end

  // Transaction model: predicts what the outputs must be in the cycle after each edge.
  initial begin
    e = '0;
    e.ready = 1'b1;
    forever begin
      exp_t nx;
      exp_t w;
      @(posedge clk);
      nx = '0;
      nx.ready = 1'b1;
      if (!rstN) begin
        m_op2   = 1'b0;
        m_fault = 1'b0;
        m_hi    = 4'h0;
        m_ret   = 12'h000;
        sched.delete();
        chk_en  = 1'b1;
      end else if (m_fault) begin
        nx.ready = 1'b0;
        nx.fault = 1'b1;
      end else if (sched.size() != 0) begin
        nx = sched.pop_front();
      end else if (instValid && e.ready) begin
        if (m_op2) begin
          m_op2     = 1'b0;
          nx.push   = 1'b1;
          nx.pcin   = m_ret;
          nx.pcld   = 1'b1;
          nx.pcnext = {m_hi, instByte};
          nx.done   = 1'b1;
          nx.ready  = 1'b0;
          m_stk.push_back(m_ret);
        end else if (instByte[7:4] == 4'h5) begin
          if (GUARD && stkSp == 3'd7) begin
            m_fault  = 1'b1;
            nx.ready = 1'b0;
            nx.fault = 1'b1;
          end else begin
            m_op2 = 1'b1;
            m_hi  = instByte[3:0];
            m_ret = 12'(instPc + 12'd2);
          end
        end else if (instByte[7:4] == 4'hC) begin
          if (GUARD && stkSp == 3'd0) begin
            m_fault  = 1'b1;
            nx.ready = 1'b0;
            nx.fault = 1'b1;
          end else begin
            nx.pop   = 1'b1;
            nx.ready = 1'b0;
            w        = '0;
            w.pcld   = 1'b1;
            w.pcnext = (m_stk.size() != 0) ? m_stk.pop_back() : 12'h000;
            w.accld  = 1'b1;
            w.accd   = instByte[3:0];
            w.done   = 1'b1;
            sched.push_back(w);
          end
        end
      end
      e = nx;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("instReady", 32'(instReady), 32'(e.ready));
      chk("stkPush",   32'(stkPush),   32'(e.push));
      chk("stkPop",    32'(stkPop),    32'(e.pop));
      chk("pcLoad",    32'(pcLoad),    32'(e.pcld));
      chk("accLoad",   32'(accLoad),   32'(e.accld));
      chk("done",      32'(done),      32'(e.done));
      chk("fault",     32'(fault),     32'(e.fault));
      if (e.push)  chk("stkPcIn", 32'(stkPcIn), 32'(e.pcin));
      if (e.pcld)  chk("pcNext",  32'(pcNext),  32'(e.pcnext));
      if (e.accld) chk("accData", 32'(accData), 32'(e.accd));
    end
  end

  task automatic send(input logic [7:0] b, input logic [11:0] pc);
    int n;
    n = 0;
    instValid = 1'b1;
    instByte  = b;
    instPc    = pc;
    while (instReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_ready", 32'(instReady), 32'h1);
    @(posedge clk);
    #1;
    instValid = 1'b0;
  endtask

  task automatic idle(input int n);
    instValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN      = 1'b0;
    instValid = 1'b0;
    instByte  = 8'h00;
    instPc    = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   32'(instReady), 32'h1);
    chk("rst_push",    32'(stkPush),   32'h0);
    chk("rst_pcld",    32'(pcLoad),    32'h0);
    chk("rst_pcnext",  32'(pcNext),    32'h000);
    chk("rst_pcin",    32'(stkPcIn),   32'h000);
    chk("rst_accdata", 32'(accData),   32'h0);
    chk("rst_fault",   32'(fault),     32'h0);
    rstN = 1'b1;

    send(8'h52, 12'h100);
    chk("jms1_no_push", 32'(stkPush), 32'h0);
    send(8'h34, 12'h101);
    chk("jms_push",   32'(stkPush),   32'h1);
    chk("jms_pcin",   32'(stkPcIn),   32'h102);
    chk("jms_pcld",   32'(pcLoad),    32'h1);
    chk("jms_pcnext", 32'(pcNext),    32'h234);
    chk("jms_done",   32'(done),      32'h1);
    chk("jms_busy",   32'(instReady), 32'h0);
    idle(1);
    chk("jms_push_once", 32'(stkPush),   32'h0);
    chk("jms_ready_back", 32'(instReady), 32'h1);

    send(8'hC7, 12'h234);
    chk("bbl_pop",     32'(stkPop), 32'h1);
    chk("bbl_no_pcld", 32'(pcLoad), 32'h0);
    idle(1);
    chk("bbl_pcld",    32'(pcLoad),  32'h1);
    chk("bbl_pcnext",  32'(pcNext),  32'h102);
    chk("bbl_accld",   32'(accLoad), 32'h1);
    chk("bbl_accdata", 32'(accData), 32'h7);
    chk("bbl_done",    32'(done),    32'h1);
    chk("bbl_pop_once", 32'(stkPop), 32'h0);
    idle(1);

    send(8'h50, 12'hFFF);
    send(8'h00, 12'h000);
    chk("wrap_pcin",   32'(stkPcIn), 32'h001);
    chk("wrap_pcnext", 32'(pcNext),  32'h000);
    idle(1);
    send(8'hC3, 12'h000);
    idle(1);
    chk("wrap_ret",     32'(pcNext),  32'h001);
    chk("wrap_accdata", 32'(accData), 32'h3);
    idle(1);

    send(8'h5A, 12'h300);
    pulse_reset();
    chk("midrst_ready", 32'(instReady), 32'h1);
    repeat (3) begin
      idle(1);
      chk("midrst_no_push", 32'(stkPush), 32'h0);
    end
    send(8'h53, 12'h200);
    send(8'h21, 12'h201);
    chk("fresh_push",   32'(stkPush), 32'h1);
    chk("fresh_pcnext", 32'(pcNext),  32'h321);
    chk("fresh_pcin",   32'(stkPcIn), 32'h202);
    idle(1);
    send(8'hC5, 12'h321);
    idle(1);
    chk("fresh_ret", 32'(pcNext), 32'h202);
    idle(1);

    send(8'hC0, 12'h010);
`ifdef SUBR_STACK_GUARD_EN
    chk("under_no_pop", 32'(stkPop),    32'h0);
    chk("under_fault",  32'(fault),     32'h1);
    chk("under_ready",  32'(instReady), 32'h0);
    idle(3);
    chk("under_fault_hold", 32'(fault),     32'h1);
    chk("under_ready_hold", 32'(instReady), 32'h0);
`else
    chk("under_pop", 32'(stkPop), 32'h1);
    idle(1);
    chk("under_pcld",   32'(pcLoad), 32'h1);
    chk("under_pcnext", 32'(pcNext), 32'h000);
`endif
    idle(1);
    pulse_reset();
    chk("fault_cleared", 32'(fault), 32'h0);

    for (int i = 0; i < 7; i++) begin
      send(8'(8'h50 + i), 12'(12'h500 + 2 * i));
      send(8'(8'h10 + i), 12'(12'h501 + 2 * i));
    end
    send(8'h51, 12'h400);
`ifdef SUBR_STACK_GUARD_EN
    chk("over_fault", 32'(fault),     32'h1);
    chk("over_ready", 32'(instReady), 32'h0);
    idle(2);
    chk("over_no_push", 32'(stkPush), 32'h0);
`else
    chk("over_no_fault", 32'(fault), 32'h0);
    send(8'h99, 12'h401);
    chk("over_push",   32'(stkPush), 32'h1);
    chk("over_pcin",   32'(stkPcIn), 32'h402);
    chk("over_pcnext", 32'(pcNext),  32'h199);
`endif
    idle(1);
    pulse_reset();

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      rstN      = ($urandom_range(0, 99) != 0);
      instValid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: instByte = {OPC_JMS, 4'($urandom)};
        3, 4, 5: instByte = {OPC_BBL, 4'($urandom)};
        default: instByte = 8'($urandom);
      endcase
      instPc = 12'($urandom);
    end
    @(negedge clk);
    #1;
    instValid = 1'b0;
    rstN      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/subr_ctrl.md
# subr_ctrl

Subroutine sequencer for the 4004-style core. It decodes JMS (two-byte call) and BBL (return with accumulator load) from the fetch stream and drives the 8-entry return-address stack's push/pop strobes. It waits out the stack's one-cycle read latency, then issues the PC redirect and accumulator load. It sits between the fetch unit, the stack, the PC register and the accumulator.

## Interface
- No parameters; depth, widths and opcodes are fixed constants (see Structure).
- clk  in  1  system clock, all state on rising edge
- rstN  in  1  reset, synchronous, active-low
- instValid  in  1  fetch presents a byte on instByte
- instByte  in  8  instruction/operand byte
- instPc  in  12  address of the byte on instByte
- instReady  out  1  controller accepts instByte this cycle
- stkPush  out  1  one-cycle push strobe to stack
- stkPop  out  1  one-cycle pop strobe to stack
- stkPcIn  out  12  return address to push
- stkPcOut  in  12  popped address, valid the cycle after stkPop
- stkSp  in  3  stack pointer (0 = empty, 7 = full)
- pcLoad  out  1  one-cycle PC redirect strobe
- pcNext  out  12  redirect target, valid with pcLoad
- accLoad  out  1  one-cycle accumulator write strobe
- accData  out  4  BBL immediate, valid with accLoad
- done  out  1  one-cycle pulse when a JMS/BBL completes
- fault  out  1  sticky stack-guard fault (guard builds only)

## Operation
- A byte is accepted on cycles where instValid && instReady.
- States: IDLE, JMS_OP2, JMS_PUSH, BBL_POP, BBL_WAIT, FAULT.
- instReady is 1 in IDLE and JMS_OP2, and 0 elsewhere.
- IDLE, accepted byte 0101_AAAA (JMS):
  - Latch A as target[11:8].
  - Latch retAddr = instPc + 2, modulo 4096 (0xFFF + 2 wraps to 0x001).
  - Go to JMS_OP2.
- JMS_OP2, accepted byte: target[7:0] = byte; go to JMS_PUSH. No other decode happens while in JMS_OP2.
- JMS_PUSH, single cycle:
  - stkPush=1, stkPcIn=retAddr.
  - pcLoad=1, pcNext=target.
  - done=1.
  - Go to IDLE.
- IDLE, accepted byte 1100_DDDD (BBL): latch D; go to BBL_POP.
- BBL_POP: stkPop=1 for one cycle; go to BBL_WAIT.
- BBL_WAIT: pcLoad=1, pcNext=stkPcOut, accLoad=1, accData=D, done=1; go to IDLE.
- IDLE, any other opcode: the byte is accepted and ignored. No strobes, no state change.
- stkPush and stkPop are never asserted in the same cycle.
- Every strobe output is exactly one cycle wide.
- Reset (rstN=0 at an edge), including mid-sequence:
  - Next state is IDLE.
  - All strobes and done/fault clear to 0; pcNext, stkPcIn and accData clear to 0.
  - Latched target, retAddr and D clear to 0.
  - A partially decoded JMS is discarded.

## Timing
- JMS: byte 1 accepted at edge N, byte 2 at edge ≥N+1. Push and redirect happen in the cycle after byte 2; earliest is cycle N+2.
- If instValid is low in JMS_OP2, the controller stalls there indefinitely.
- BBL: accepted at edge N; stkPop in cycle N+1; pcLoad/accLoad/done in cycle N+2.
- Next byte can be accepted the cycle after done.
- Outputs are registered; no combinational path from instByte to any strobe.

## Configuration
- SUBR_STACK_GUARD_EN defined:
  - JMS decode with stkSp==7 goes to FAULT instead of JMS_OP2.
  - BBL decode with stkSp==0 goes to FAULT.
  - In FAULT: no push/pop is issued, fault=1, instReady=0, and the block holds until reset.
- SUBR_STACK_GUARD_EN undefined:
  - stkSp is ignored and FAULT is unreachable; fault is tied to 0.
  - Push/pop are issued unconditionally. The stack's own overflow/underflow flags report misuse, and an underflowing BBL redirects to stkPcOut (0x000).

## Structure
- Package subr_pkg:
  - OPC_JMS=4'b0101, OPC_BBL=4'b1100.
  - STK_SP_FULL=3'd7, STK_SP_EMPTY=3'd0.
  - Typedef subr_state_t for the six states.
  - ADDR_W=12.
- Sub-module subr_decode: combinational, instByte → isJms, isBbl, nibble. Instanced once in subr_ctrl.

## Test plan
- JMS 0x52 @instPc=0x100, then 0x34 → one-cycle stkPush with stkPcIn=0x102; pcLoad with pcNext=0x234; done=1; back in IDLE.
- Stack holds 0x102 (stkPcOut=0x102 after pop); BBL 0xC7 → stkPop at N+1; at N+2 pcLoad pcNext=0x102, accLoad accData=0x7, done=1.
- JMS at instPc=0xFFF, operand 0x00 with first byte 0x50 → stkPcIn=0x001, pcNext=0x000.
- JMS first byte accepted, then rstN=0 for one cycle → no stkPush ever; next valid byte decoded fresh from IDLE.
- Guard build, stkSp=7, JMS 0x51 → no stkPush, fault=1 from next cycle, instReady=0 until reset. Non-guard build, same stimulus → stkPush asserted normally.
- Guard build, stkSp=0, BBL 0xC0 → no stkPop, fault=1. Non-guard build → stkPop, pcNext=stkPcOut=0x000.
